// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with a start/busy/done handshake.
// Shift-add multiply and restoring divide both run on magnitudes; the sign is applied once at the end.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            kill,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;

  logic              a_signed, b_signed, a_neg, b_neg, neg_cap;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_val;
  logic              accept, last;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_final;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem_next, div_quo_next, quo_final, rem_final;
  logic [XLEN-1:0]   final_val;

  // Operand conditioning at capture: magnitudes, result sign and divide special cases.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
    a_neg    = a_signed & opa[XLEN-1];
    b_neg    = b_signed & opb[XLEN-1];
    a_mag    = a_neg ? -opa : opa;
    b_mag    = b_neg ? -opb : opb;
    neg_cap  = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = funct3[2] & (opb == '0);
    div_ovf  = funct3[2] & ~funct3[0] & (opa == {1'b1, {(XLEN-1){1'b0}}}) & (opb == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_val = funct3[1] ? opa : '1;
    else          fast_val = funct3[1] ? '0 : opa;
  end

  assign accept = start & ~kill & ((state == IDLE) | (state == DONE));
  assign last   = (state == RUN) & (cnt == CW'(XLEN - 1));

  // One iteration step of each algorithm plus the sign-corrected final value.
  always_comb begin
    mul_sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next     = {mul_sum, acc[XLEN-1:1]};
    div_shift    = {rem, acc[XLEN-1]};
    div_ge       = div_shift >= {1'b0, mcand};
    div_rem_next = div_ge ? XLEN'(div_shift - {1'b0, mcand}) : div_shift[XLEN-1:0];
    div_quo_next = {acc[XLEN-2:0], div_ge};
    prod_final   = neg ? -mul_next : mul_next;
    quo_final    = neg ? -div_quo_next : div_quo_next;
    rem_final    = neg ? -div_rem_next : div_rem_next;
    case (op)
      3'b000:                 final_val = prod_final[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_final[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = quo_final;
      default:                final_val = rem_final;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = fast ? DONE : RUN;
      RUN:  if (last) state_next = DONE;
      DONE: begin
        if (accept) state_next = fast ? DONE : RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  // The low half of acc doubles as the multiplier or the dividend/quotient shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op     <= '0;
      neg    <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      rem    <= '0;
      result <= '0;
    end else if (kill) begin
      cnt <= '0;
    end else if (accept) begin
      op    <= funct3;
      neg   <= neg_cap;
      mcand <= funct3[2] ? b_mag : a_mag;
      acc   <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
      rem   <= '0;
      cnt   <= '0;
      if (fast) result <= fast_val;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (op[2]) begin
        rem             <= div_rem_next;
        acc[XLEN-1:0]   <= div_quo_next;
      end else begin
        acc <= mul_next;
      end
      if (last) result <= final_val;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
